// File: rtl/stat_sampler_pkg.sv
// stat_sampler_pkg: shared FSM encoding and helpers for the statistics sampler
package stat_sampler_pkg;
    localparam int OVERRUN_WIDTH = 16;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_SEL  = 3'd1;
    localparam state_t S_WAIT = 3'd2;
    localparam state_t S_CAP  = 3'd3;
    localparam state_t S_OUT  = 3'd4;
    function automatic logic [OVERRUN_WIDTH-1:0] sat_inc(input logic [OVERRUN_WIDTH-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/stat_interval_timer.sv
// stat_interval_timer: reload down-counter emitting a one-cycle pulse every interval enabled cycles
module stat_interval_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [WIDTH-1:0] interval,
    output logic             expire
);
    logic [WIDTH-1:0] cnt;
    logic             active;
    assign active = run && interval != '0;
    // cnt==0 stands for "freshly loaded with interval", so the first active cycle counts as one step
    assign expire = active && (cnt == WIDTH'(1) || (cnt == '0 && interval == WIDTH'(1)));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (active)
            cnt <= expire ? interval : cnt == '0 ? interval - 1'b1 : cnt - 1'b1;
endmodule

// File: rtl/stat_sampler.sv
// stat_sampler: sweeps the counter bank and streams wrap-safe per-port deltas each sweep
module stat_sampler
    import stat_sampler_pkg::*;
#(
    parameter int PORT_COUNT        = 4,
    parameter int PORT_WIDTH        = $clog2(PORT_COUNT),
    parameter int BYTE_COUNT_WIDTH  = 32,
    parameter int FRAME_COUNT_WIDTH = 32,
    parameter int INTERVAL_WIDTH    = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        enable,
    input  logic [INTERVAL_WIDTH-1:0]                   interval,
    input  logic                                        trigger,
    input  logic [PORT_COUNT-1:0]                       port_clear,
    output logic [PORT_WIDTH-1:0]                       port_select,
    input  logic [BYTE_COUNT_WIDTH-1:0]                 byte_count,
    input  logic [FRAME_COUNT_WIDTH-1:0]                frame_count,
    output logic [FRAME_COUNT_WIDTH+BYTE_COUNT_WIDTH-1:0] m_axis_tdata,
    output logic [PORT_WIDTH-1:0]                       m_axis_tid,
    output logic                                        m_axis_tuser,
    output logic                                        m_axis_tlast,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic                                        busy,
    output logic [OVERRUN_WIDTH-1:0]                    overrun_count
);
    state_t                         state;
    logic                           req;
    logic [PORT_WIDTH-1:0]          port;
    logic [BYTE_COUNT_WIDTH-1:0]    prev_b [PORT_COUNT];
    logic [FRAME_COUNT_WIDTH-1:0]   prev_f [PORT_COUNT];
    logic [PORT_COUNT-1:0]          clear_seen;
    logic                           expire;
    logic                           last;
    logic                           start;
    logic                           hs;

    stat_interval_timer #(.WIDTH(INTERVAL_WIDTH)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (enable),
        .interval(interval),
        .expire  (expire)
    );

    assign last  = port == PORT_WIDTH'(PORT_COUNT - 1);
    assign start = state == S_IDLE && req && enable;
    assign hs    = m_axis_tvalid && m_axis_tready;
    assign busy  = state != S_IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= S_IDLE;
            req           <= 1'b0;
            port          <= '0;
            port_select   <= '0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            overrun_count <= '0;
        end else begin
            req <= expire || (trigger && enable) || (req && !start);
            if (expire && busy)
                overrun_count <= sat_inc(overrun_count);
            case (state)
                S_IDLE: if (start) begin
                    port  <= '0;
                    state <= S_SEL;
                end
                S_SEL: begin
                    port_select <= port;
                    state       <= S_WAIT;
                end
                S_WAIT: state <= S_CAP;
                S_CAP: begin
                    m_axis_tdata  <= {frame_count - prev_f[port], byte_count - prev_b[port]};
                    m_axis_tid    <= port;
                    m_axis_tuser  <= clear_seen[port];
                    m_axis_tlast  <= last;
                    m_axis_tvalid <= 1'b1;
                    state         <= S_OUT;
                end
                S_OUT: if (hs) begin
                    m_axis_tvalid <= 1'b0;
                    port          <= port + 1'b1;
                    state         <= last ? S_IDLE : S_SEL;
                end
                default: state <= S_IDLE;
            endcase
        end

    // a clear beats the capture of the same port so the restart is never lost
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            prev_b     <= '{default: '0};
            prev_f     <= '{default: '0};
            clear_seen <= '0;
        end else begin
            for (int i = 0; i < PORT_COUNT; i++)
                if (port_clear[i]) begin
                    prev_b[i]     <= '0;
                    prev_f[i]     <= '0;
                    clear_seen[i] <= 1'b1;
                end else if (state == S_CAP && port == PORT_WIDTH'(i)) begin
                    prev_b[i]     <= byte_count;
                    prev_f[i]     <= frame_count;
                    clear_seen[i] <= 1'b0;
                end
        end
endmodule

// File: tb/tb_stat_sampler.sv
// tb_stat_sampler: directed sweeps checked against a transaction-level model of the sampler
module tb_stat_sampler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        trigger = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic [31:0] interval = '0;
    logic [3:0]  port_clear = '0;
    logic [1:0]  port_select, m_axis_tid;
    logic [31:0] byte_count, frame_count;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid, busy;
    logic [15:0] overrun_count;
    logic [31:0] bank_b [4];
    logic [31:0] bank_f [4];
    int          errors = 0;
    int          checks = 0;

    logic [31:0] mprev_b [4];
    logic [31:0] mprev_f [4];
    logic [3:0]  mseen;
    int          mport, mk, rec_count, cyc;
    logic        msweep, mreq, m_exp, m_start;
    logic [15:0] movr;
    logic        stall;
    logic [63:0] h_data;
    logic [1:0]  h_tid, last_ps;
    logic        h_user, h_last;
    logic [63:0] got_data [4];
    logic        got_user [4];
    logic        got_last [4];
    int          ps_t [4];

    always #5 clk = ~clk;

    stat_sampler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .interval     (interval),
        .trigger      (trigger),
        .port_clear   (port_clear),
        .port_select  (port_select),
        .byte_count   (byte_count),
        .frame_count  (frame_count),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tid   (m_axis_tid),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy         (busy),
        .overrun_count(overrun_count)
    );

    // counter bank with one registered output stage behind port_select
    always @(posedge clk) begin
        byte_count  <= bank_b[port_select];
        frame_count <= bank_f[port_select];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model and compare: sampled at negedge, predicting the effect of the coming posedge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mprev_b[i] = '0;
                mprev_f[i] = '0;
            end
            mseen = '0; mport = 0; mk = 0; msweep = 1'b0; mreq = 1'b0; movr = '0; stall = 1'b0;
        end else begin
            chk("busy", busy, msweep);
            chk("overrun", overrun_count, movr);
            if (port_select != last_ps) begin
                ps_t[port_select] = cyc;
                last_ps = port_select;
            end
            if (stall) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, h_data);
                chk("hold_tid", m_axis_tid, h_tid);
                chk("hold_user", m_axis_tuser, h_user);
                chk("hold_last", m_axis_tlast, h_last);
            end
            if (m_axis_tvalid)
                chk("sel_vs_tid", port_select, m_axis_tid);
            stall = m_axis_tvalid && !m_axis_tready;
            h_data = m_axis_tdata; h_tid = m_axis_tid; h_user = m_axis_tuser; h_last = m_axis_tlast;
            m_exp = 1'b0;
            if (enable && interval != 0) begin
                mk++;
                if (mk == interval) begin
                    mk = 0;
                    m_exp = 1'b1;
                end
            end
            if (m_exp && msweep && movr != 16'hFFFF)
                movr = movr + 1'b1;
            m_start = !msweep && mreq && enable;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("tid", m_axis_tid, mport);
                chk("tdata", m_axis_tdata, {bank_f[mport] - mprev_f[mport], bank_b[mport] - mprev_b[mport]});
                chk("tuser", m_axis_tuser, mseen[mport]);
                chk("tlast", m_axis_tlast, mport == 3);
                got_data[mport] = m_axis_tdata;
                got_user[mport] = m_axis_tuser;
                got_last[mport] = m_axis_tlast;
                mprev_b[mport] = bank_b[mport];
                mprev_f[mport] = bank_f[mport];
                mseen[mport] = 1'b0;
                rec_count++;
                if (mport == 3) begin
                    mport = 0;
                    msweep = 1'b0;
                end else
                    mport++;
            end
            if (m_start)
                msweep = 1'b1;
            mreq = (mreq && !m_start) || m_exp || (trigger && enable);
            for (int i = 0; i < 4; i++)
                if (port_clear[i]) begin
                    mprev_b[i] = '0;
                    mprev_f[i] = '0;
                    mseen[i] = 1'b1;
                end
        end
    end

    task automatic pulse_trigger();
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
    endtask

    task automatic wait_recs(input int target);
        for (int i = 0; i < 400 && rec_count < target; i++) @(posedge clk);
        chk("record_count", rec_count, target);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_tid(input logic [1:0] t);
        for (int i = 0; i < 200 && !(m_axis_tvalid && m_axis_tid == t); i++) begin
            @(posedge clk); #1;
        end
        chk("reached_tid", m_axis_tvalid && m_axis_tid == t, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            bank_b[i] = '0;
            bank_f[i] = '0;
        end
        last_ps = '0;
        rec_count = 0;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", port_select, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_ovr", overrun_count, 0);
        rst_n = 1'b1;

        bank_b = '{32'd100, 32'd200, 32'd300, 32'd400};
        bank_f = '{32'd1, 32'd2, 32'd3, 32'd4};
        pulse_trigger();
        wait_recs(4);
        chk("s1_p0", got_data[0], {32'd1, 32'd100});
        chk("s1_p3", got_data[3], {32'd4, 32'd400});
        chk("s1_last0", got_last[0], 0);
        chk("s1_last3", got_last[3], 1);
        chk("sel_gap12", ps_t[2] - ps_t[1], 4);
        chk("sel_gap23", ps_t[3] - ps_t[2], 4);

        bank_b[0] = 32'd150;
        bank_b[1] = 32'hFFFF_FFF0;
        pulse_trigger();
        wait_tid(2'd2);
        m_axis_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_sel", port_select, 2);
        chk("bp_tid", m_axis_tid, 2);
        chk("bp_no_tid3", rec_count, 6);
        m_axis_tready = 1'b1;
        wait_recs(8);
        chk("s2_p0_bytes", got_data[0][31:0], 32'd50);

        bank_b[1] = 32'h10;
        pulse_trigger();
        wait_recs(12);
        chk("wrap_bytes", got_data[1][31:0], 32'h20);
        chk("wrap_frames", got_data[1][63:32], 0);

        port_clear = 4'b0010;
        @(posedge clk); #1 port_clear = '0;
        bank_b[1] = 32'd40;
        bank_f[1] = 32'd7;
        pulse_trigger();
        wait_recs(16);
        chk("clr_delta", got_data[1], {32'd7, 32'd40});
        chk("clr_user1", got_user[1], 1);
        chk("clr_user0", got_user[0], 0);
        pulse_trigger();
        wait_recs(20);
        chk("clr_user_next", got_user[1], 0);
        chk("clr_delta_next", got_data[1], 0);

        m_axis_tready = 1'b0;
        pulse_trigger();
        wait_tid(2'd0);
        interval = 32'd8;
        repeat (40) @(posedge clk);
        #1;
        chk("ovr_five", overrun_count, 5);
        interval = '0;
        m_axis_tready = 1'b1;
        wait_recs(28);
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_one_extra", rec_count, 28);
        chk("ovr_idle", busy, 0);

        pulse_trigger();
        wait_tid(2'd2);
        m_axis_tready = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sel", port_select, 0);
        chk("arst_ovr", overrun_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
